parking_zone_ctrl: RTL

Multi-gate, two-class (university / public) parking occupancy controller with a parametrised hourly capacity schedule. It accepts per-gate entry and exit requests and returns a registered grant or deny for each. It keeps registered occupancy counts and a prescaled hour-of-day clock, and clears all state at closing time. It sits between the gate sensor front-end and the vacancy display.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/parking_class_arbiter.sv | 53 +++++
 rtl/parking_zone_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types, widths and the university capacity schedule for the parking zone controller.
package parking_pkg;

  localparam int HOUR_W = 5;

  typedef enum logic {
    CLASS_PUBLIC = 1'b0,
    CLASS_UNI    = 1'b1
  } car_class_e;

  // University capacity for a given hour: flat, then a stepped reduction, then a floor.
  function automatic int uni_cap_at(input int hour, input int cap_max, input int cap_min,
                                    input int shift_start, input int shift_end, input int step);
    if (hour < shift_start)
      return cap_max;
    else if (hour < shift_end)
      return cap_max - step * (hour - shift_start + 1);
    else
      return cap_min;
  endfunction

endpackage

// File: rtl/parking_class_arbiter.sv
// Single-class arbitration: exits first, then entries, both in ascending gate order.
module parking_class_arbiter #(
  parameter int NUM_GATES = 2,
  parameter int CNT_W     = 10
) (
  input  logic [CNT_W-1:0]     i_count,
  input  logic [CNT_W-1:0]     i_cap,
  input  logic [NUM_GATES-1:0] i_entry,
  input  logic [NUM_GATES-1:0] i_exit,
  output logic [NUM_GATES-1:0] o_entry_grant,
  output logic [NUM_GATES-1:0] o_entry_deny,
  output logic [NUM_GATES-1:0] o_exit_grant,
  output logic [NUM_GATES-1:0] o_exit_deny,
  output logic [CNT_W-1:0]     o_next_count
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic [CNT_W:0] w_run;
  logic [CNT_W:0] w_cap;

  // Space freed by exits is visible to entries in the same cycle via the running count.
  always_comb begin
    o_entry_grant = '0;
    o_entry_deny  = '0;
    o_exit_grant  = '0;
    o_exit_deny   = '0;
    w_run         = {1'b0, i_count};
    w_cap         = {1'b0, i_cap};
    for (int g = 0; g < NUM_GATES; g++) begin
      if (i_exit[g]) begin
        if (w_run != '0) begin
          o_exit_grant[g] = 1'b1;
          w_run           = w_run - ONE;
        end else begin
          o_exit_deny[g] = 1'b1;
        end
      end
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      if (i_entry[g]) begin
        if (w_run < w_cap) begin
          o_entry_grant[g] = 1'b1;
          w_run            = w_run + ONE;
        end else begin
          o_entry_deny[g] = 1'b1;
        end
      end
    end
    o_next_count = w_run[CNT_W-1:0];
  end

endmodule

// File: rtl/parking_zone_ctrl.sv
// Two-class parking occupancy controller with hourly capacity schedule and daily rollover.
// Optional per-day statistics outputs are enabled by defining PARKING_STATS_EN.
module parking_zone_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_GATES     = 2,
  parameter int CNT_W         = 10,
  parameter int CLKS_PER_HOUR = 10,
  parameter int OPEN_HOUR     = 8,
  parameter int CLOSE_HOUR    = 24,
  parameter int TOTAL_CAP     = 700,
  parameter int UNI_CAP_MAX   = 500,
  parameter int UNI_CAP_MIN   = 200,
  parameter int SHIFT_START   = 13,
  parameter int SHIFT_END     = 16,
  parameter int SHIFT_STEP    = 50
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_GATES-1:0] i_entry_valid,
  input  logic [NUM_GATES-1:0] i_entry_uni,
  input  logic [NUM_GATES-1:0] i_exit_valid,
  input  logic [NUM_GATES-1:0] i_exit_uni,
  output logic [NUM_GATES-1:0] o_entry_grant,
  output logic [NUM_GATES-1:0] o_entry_deny,
  output logic [NUM_GATES-1:0] o_exit_grant,
  output logic [NUM_GATES-1:0] o_exit_deny,
  output logic [CNT_W-1:0]     o_uni_parked_cars,
  output logic [CNT_W-1:0]     o_parked_cars,
  output logic [CNT_W-1:0]     o_uni_vacated_space,
  output logic [CNT_W-1:0]     o_vacated_space,
  output logic                 o_uni_is_vacated_space,
  output logic                 o_is_vacated_space,
  output logic [HOUR_W-1:0]    o_hour,
`ifdef PARKING_STATS_EN
  output logic [15:0]          o_uni_denied_cnt,
  output logic [15:0]          o_denied_cnt,
  output logic [CNT_W-1:0]     o_uni_peak,
  output logic [CNT_W-1:0]     o_peak,
`endif
  output logic                 o_day_end
);

  localparam int PRE_W = (CLKS_PER_HOUR > 1) ? $clog2(CLKS_PER_HOUR) : 1;

  logic [PRE_W-1:0]     r_presc;
  logic [HOUR_W-1:0]    r_hour;
  logic [CNT_W-1:0]     r_cnt [2];
  logic [NUM_GATES-1:0] r_entry_grant, r_entry_deny, r_exit_grant, r_exit_deny;
  logic                 r_day_end;

  logic                 w_wrap, w_roll;
  logic [CNT_W-1:0]     w_cap [2];
  logic [CNT_W-1:0]     w_vac [2];
  logic [CNT_W-1:0]     w_next [2];
  logic [NUM_GATES-1:0] w_eg [2];
  logic [NUM_GATES-1:0] w_ed [2];
  logic [NUM_GATES-1:0] w_xg [2];
  logic [NUM_GATES-1:0] w_xd [2];

  assign w_wrap = (r_presc == PRE_W'(CLKS_PER_HOUR - 1));
  assign w_roll = w_wrap && (r_hour == HOUR_W'(CLOSE_HOUR - 1));

  always_comb begin
    w_cap[1] = CNT_W'(uni_cap_at(int'(r_hour), UNI_CAP_MAX, UNI_CAP_MIN,
                                 SHIFT_START, SHIFT_END, SHIFT_STEP));
    w_cap[0] = CNT_W'(TOTAL_CAP) - w_cap[1];
    for (int c = 0; c < 2; c++)
      w_vac[c] = (w_cap[c] > r_cnt[c]) ? (w_cap[c] - r_cnt[c]) : '0;
  end

  for (genvar c = 0; c < 2; c++) begin : g_class
    localparam car_class_e CLS = car_class_e'(c);
    logic [NUM_GATES-1:0] w_entry_mask, w_exit_mask;

    assign w_entry_mask = i_entry_valid & ((CLS == CLASS_UNI) ? i_entry_uni : ~i_entry_uni);
    assign w_exit_mask  = i_exit_valid  & ((CLS == CLASS_UNI) ? i_exit_uni  : ~i_exit_uni);

    parking_class_arbiter #(.NUM_GATES(NUM_GATES), .CNT_W(CNT_W)) u_arb (
      .i_count       (r_cnt[c]),
      .i_cap         (w_cap[c]),
      .i_entry       (w_entry_mask),
      .i_exit        (w_exit_mask),
      .o_entry_grant (w_eg[c]),
      .o_entry_deny  (w_ed[c]),
      .o_exit_grant  (w_xg[c]),
      .o_exit_deny   (w_xd[c]),
      .o_next_count  (w_next[c])
    );
  end

  // Rollover overrides arbitration: the day is closed, so every request that cycle is refused.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc       <= '0;
      r_hour        <= HOUR_W'(OPEN_HOUR);
      r_cnt[0]      <= '0;
      r_cnt[1]      <= '0;
      r_entry_grant <= '0;
      r_entry_deny  <= '0;
      r_exit_grant  <= '0;
      r_exit_deny   <= '0;
      r_day_end     <= 1'b0;
    end else begin
      r_presc   <= w_wrap ? '0 : r_presc + PRE_W'(1);
      r_day_end <= w_roll;
      if (w_roll) begin
        r_hour        <= HOUR_W'(OPEN_HOUR);
        r_cnt[0]      <= '0;
        r_cnt[1]      <= '0;
        r_entry_grant <= '0;
        r_entry_deny  <= i_entry_valid;
        r_exit_grant  <= '0;
        r_exit_deny   <= i_exit_valid;
      end else begin
        if (w_wrap)
          r_hour <= r_hour + HOUR_W'(1);
        r_cnt[0]      <= w_next[0];
        r_cnt[1]      <= w_next[1];
        r_entry_grant <= w_eg[0] | w_eg[1];
        r_entry_deny  <= w_ed[0] | w_ed[1];
        r_exit_grant  <= w_xg[0] | w_xg[1];
        r_exit_deny   <= w_xd[0] | w_xd[1];
      end
    end
  end

`ifdef PARKING_STATS_EN
  logic [15:0]      r_den [2];
  logic [CNT_W-1:0] r_peak [2];
  logic [16:0]      w_den_sum [2];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_den_sum[c] = {1'b0, r_den[c]};
      for (int g = 0; g < NUM_GATES; g++)
        w_den_sum[c] = w_den_sum[c] + 17'(w_ed[c][g]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (!i_reset && w_roll)) begin
      for (int c = 0; c < 2; c++) begin
        r_den[c]  <= '0;
        r_peak[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_den[c]  <= w_den_sum[c][16] ? 16'hFFFF : w_den_sum[c][15:0];
        r_peak[c] <= (w_next[c] > r_peak[c]) ? w_next[c] : r_peak[c];
      end
    end
  end

  assign o_uni_denied_cnt = r_den[1];
  assign o_denied_cnt     = r_den[0];
  assign o_uni_peak       = r_peak[1];
  assign o_peak           = r_peak[0];
`endif

  assign o_entry_grant          = r_entry_grant;
  assign o_entry_deny           = r_entry_deny;
  assign o_exit_grant           = r_exit_grant;
  assign o_exit_deny            = r_exit_deny;
  assign o_uni_parked_cars      = r_cnt[1];
  assign o_parked_cars          = r_cnt[0];
  assign o_uni_vacated_space    = w_vac[1];
  assign o_vacated_space        = w_vac[0];
  assign o_uni_is_vacated_space = (w_vac[1] != '0);
  assign o_is_vacated_space     = (w_vac[0] != '0);
  assign o_hour                 = r_hour;
  assign o_day_end              = r_day_end;

endmodule
